// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM state encoding and PC mux selects.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_INTR  = 2'd2
    } state_e;

    localparam logic [1:0] SEL_IMMED  = 2'd0;
    localparam logic [1:0] SEL_STACK  = 2'd1;
    localparam logic [1:0] SEL_VECTOR = 2'd2;
    localparam logic [1:0] SEL_ZERO   = 2'd3;

endpackage

// File: rtl/pc_seq_ctrl_fetch_wait_cnt.sv
// Counts instruction-memory wait cycles while the sequencer sits in FETCH.
module fetch_wait_cnt #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [1:0] LAST = FETCH_WAIT[1:0];

    logic [1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == LAST);

    // Restart from zero whenever FETCH is left or its final cycle is reached.
    always_comb begin
        cnt_d = 2'd0;
        if (en_i && !done_o) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: FETCH/EXEC/INTR control strobes for PC, stack and IR.
// Interrupt support is present only when PC_SEQ_INT_EN is defined.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BRANCH_REQ,
    input  logic       COND_MET,
    input  logic       CALL_REQ,
    input  logic       RET_REQ,
    input  logic       INT_REQ,
    input  logic       IE,
    output logic [1:0] PC_MUX_SEL,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic       SP_INCR,
    output logic       SP_DECR,
    output logic       PUSH_PC,
    output logic       I_CLR,
    output logic       FETCH_STB,
    output logic [1:0] DBG_STATE
);

    state_e state_q, state_d;
    logic   wait_done;
    logic   go_intr;

    fetch_wait_cnt #(
        .FETCH_WAIT(FETCH_WAIT)
    ) u_fetch_wait_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .en_i  (state_q == ST_FETCH),
        .done_o(wait_done)
    );

`ifdef PC_SEQ_INT_EN
    logic pend_q, pend_d;
    logic int_pend;

    // A request arriving in the same EXEC cycle counts as pending.
    assign int_pend = pend_q | INT_REQ;
    assign go_intr  = int_pend & IE;

    always_comb begin
        pend_d = int_pend;
        if (state_q == ST_EXEC && go_intr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    logic unused_int_in;
    assign unused_int_in = INT_REQ ^ IE;
    assign go_intr       = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PC_MUX_SEL = SEL_IMMED;
        PC_LD      = 1'b0;
        PC_INC     = 1'b0;
        SP_INCR    = 1'b0;
        SP_DECR    = 1'b0;
        PUSH_PC    = 1'b0;
        I_CLR      = 1'b0;
        FETCH_STB  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (wait_done) begin
                    FETCH_STB = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (RET_REQ) begin
                    PC_MUX_SEL = SEL_STACK;
                    PC_LD      = 1'b1;
                    SP_INCR    = 1'b1;
                end else if (CALL_REQ) begin
                    PC_MUX_SEL = SEL_IMMED;
                    PC_LD      = 1'b1;
                    SP_DECR    = 1'b1;
                    PUSH_PC    = 1'b1;
                end else if (BRANCH_REQ && COND_MET) begin
                    PC_MUX_SEL = SEL_IMMED;
                    PC_LD      = 1'b1;
                end else begin
                    PC_INC = 1'b1;
                end
                state_d = go_intr ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                PC_MUX_SEL = SEL_VECTOR;
                PC_LD      = 1'b1;
                SP_DECR    = 1'b1;
                PUSH_PC    = 1'b1;
`ifdef PC_SEQ_INT_EN
                I_CLR      = 1'b1;
`endif
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset is asynchronous, so the strobes are masked in the same cycle.
        if (RST) begin
            PC_MUX_SEL = SEL_ZERO;
            PC_LD      = 1'b0;
            PC_INC     = 1'b0;
            SP_INCR    = 1'b0;
            SP_DECR    = 1'b0;
            PUSH_PC    = 1'b0;
            I_CLR      = 1'b0;
            FETCH_STB  = 1'b0;
        end
    end

    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: per-cycle expected output vectors checked by monitors.
module tb_pc_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, br = 1'b0, cm = 1'b0, call = 1'b0, ret = 1'b0, intr = 1'b0, ie = 1'b0;
    logic [1:0] sel, dbg;
    logic ld, inc, spi, spd, push, iclr, stb;

    pc_seq_ctrl #(.FETCH_WAIT(0)) dut (
        .CLK(clk), .RST(rst), .BRANCH_REQ(br), .COND_MET(cm), .CALL_REQ(call),
        .RET_REQ(ret), .INT_REQ(intr), .IE(ie), .PC_MUX_SEL(sel), .PC_LD(ld),
        .PC_INC(inc), .SP_INCR(spi), .SP_DECR(spd), .PUSH_PC(push), .I_CLR(iclr),
        .FETCH_STB(stb), .DBG_STATE(dbg)
    );

    logic rst3 = 1'b1;
    logic [1:0] dbg3, unused3_sel;
    logic ld3, inc3, stb3, unused3_spi, unused3_spd, unused3_push, unused3_iclr;

    pc_seq_ctrl #(.FETCH_WAIT(3)) dut3 (
        .CLK(clk), .RST(rst3), .BRANCH_REQ(1'b0), .COND_MET(1'b0), .CALL_REQ(1'b0),
        .RET_REQ(1'b0), .INT_REQ(1'b0), .IE(1'b0), .PC_MUX_SEL(unused3_sel), .PC_LD(ld3),
        .PC_INC(inc3), .SP_INCR(unused3_spi), .SP_DECR(unused3_spd), .PUSH_PC(unused3_push),
        .I_CLR(unused3_iclr), .FETCH_STB(stb3), .DBG_STATE(dbg3)
    );

    // Vector: {state[1:0], sel[1:0], ld, inc, spi, spd, push, iclr, stb}
    localparam logic [10:0] E_RST  = {2'd0, 2'd3, 7'b0000000};
    localparam logic [10:0] E_F    = {2'd0, 2'd0, 7'b0000001};
    localparam logic [10:0] E_SEQ  = {2'd1, 2'd0, 7'b0100000};
    localparam logic [10:0] E_CALL = {2'd1, 2'd0, 7'b1001100};
    localparam logic [10:0] E_RET  = {2'd1, 2'd1, 7'b1010000};
    localparam logic [10:0] E_BR   = {2'd1, 2'd0, 7'b1000000};
    localparam logic [10:0] E_INTR = {2'd2, 2'd2, 7'b1001110};

    // FETCH_WAIT=3 vector: {state[1:0], stb, inc, ld}
    localparam logic [4:0] W_F = {2'd0, 3'b000};
    localparam logic [4:0] W_S = {2'd0, 3'b100};
    localparam logic [4:0] W_E = {2'd1, 3'b010};

    logic [10:0] exp_q[$];
    logic [4:0]  exp3_q[$];
    int checks = 0;
    int errors = 0;
    int idx0 = 0;
    int idx3 = 0;

    task automatic cyc(input logic r, input logic b, input logic c, input logic ca,
                       input logic re, input logic it, input logic e, input logic [10:0] exp);
        @(posedge clk);
        #1;
        rst = r; br = b; cm = c; call = ca; ret = re; intr = it; ie = e;
        exp_q.push_back(exp);
    endtask

    task automatic cyc3(input logic r, input logic [4:0] exp);
        @(posedge clk);
        #1;
        rst3 = r;
        exp3_q.push_back(exp);
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        logic [10:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {dbg, sel, ld, inc, spi, spd, push, iclr, stb};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL main_cycle_%0d: got %b required %b", idx0, act, e);
            end
            idx0++;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] act;
        if (exp3_q.size() > 0) begin
            e   = exp3_q.pop_front();
            act = {dbg3, stb3, inc3, ld3};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL wait3_cycle_%0d: got %b required %b", idx3, act, e);
            end
            idx3++;
        end
    end

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0, E_RST);
        cyc(1, 0, 0, 0, 0, 0, 0, E_RST);

        // Three plain instructions: FETCH_STB every other cycle, PC_INC in EXEC
        repeat (3) begin
            cyc(0, 0, 0, 0, 0, 0, 0, E_F);
            cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        end

        // Priority: CALL over branch, RET over CALL, taken and not-taken branch
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 1, 1, 1, 0, 0, 0, E_CALL);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 1, 1, 1, 1, 0, 0, E_RET);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 1, 1, 0, 0, 0, 0, E_BR);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 1, 0, 0, 0, 0, 0, E_SEQ);

`ifdef PC_SEQ_INT_EN
        // Pulse in FETCH with IE=1: INTR follows the EXEC
        cyc(0, 0, 0, 0, 0, 1, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 1, E_INTR);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        // Held pending through two IE=0 instructions, serviced after third EXEC
        cyc(0, 0, 0, 0, 0, 1, 0, E_F);
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 1, E_INTR);
        // Request arriving in the EXEC cycle itself, with a CALL alongside
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        cyc(0, 0, 0, 1, 0, 1, 1, E_CALL);
        cyc(0, 0, 0, 0, 0, 0, 1, E_INTR);
        // Reset during INTR
        cyc(0, 0, 0, 0, 0, 1, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        cyc(1, 0, 0, 0, 0, 0, 1, E_RST);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        // Reset clears a request held while IE=0
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        cyc(0, 0, 0, 0, 0, 1, 0, E_F);
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        cyc(1, 0, 0, 0, 0, 0, 0, E_RST);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
        cyc(0, 0, 0, 0, 0, 0, 1, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 1, E_F);
`else
        // Interrupt inputs held high are ignored
        repeat (3) begin
            cyc(0, 0, 0, 0, 0, 1, 1, E_F);
            cyc(0, 0, 0, 0, 0, 1, 1, E_SEQ);
        end
        cyc(0, 0, 0, 0, 0, 1, 1, E_F);
        cyc(0, 0, 0, 1, 0, 1, 1, E_CALL);
        cyc(0, 0, 0, 0, 0, 1, 1, E_F);
`endif

        // Reset mid-instruction aborts a CALL with no strobes
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(1, 0, 0, 1, 0, 0, 0, E_RST);
        cyc(0, 0, 0, 0, 0, 0, 0, E_F);
        cyc(0, 0, 0, 0, 0, 0, 0, E_SEQ);

        // FETCH_WAIT=3: strobe on the 4th FETCH cycle
        cyc3(1, W_F);
        cyc3(0, W_F);
        cyc3(0, W_F);
        cyc3(0, W_F);
        cyc3(0, W_S);
        cyc3(0, W_E);
        cyc3(0, W_F);
        cyc3(0, W_F);
        cyc3(0, W_F);
        cyc3(0, W_S);
        cyc3(0, W_E);

        for (int i = 0; i < 10 && (exp_q.size() > 0 || exp3_q.size() > 0); i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0 || exp3_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size() + exp3_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
